// File: rtl/shift_rows_stream.sv
// Rijndael ShiftRows / InvShiftRows stage for Nb = 4, 6 or 8 columns.
// Byte routing is applied before capture into a two-entry (main + skid) elastic buffer.
module shift_rows_stream #(
   parameter int NB    = 4,
   parameter int CNT_W = 16
) (
   input  logic                i_Clk,
   input  logic                i_Rst_n,
   input  logic                i_Clr,
   input  logic                i_Valid,
   output logic                o_Ready,
   input  logic [32*NB-1:0]    i_Data,
   input  logic                i_fDec,
   output logic                o_Valid,
   input  logic                i_Ready,
   output logic [32*NB-1:0]    o_Data,
   output logic                o_fDec,
   output logic [CNT_W-1:0]    o_Cnt
);

   localparam int W = 32 * NB;

   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_stream: NB must be 4, 6 or 8");
   end

   // Row offsets: Nb = 8 uses 1,3,4 for rows 1..3; narrower blocks use the row index.
   function automatic int row_off(input int r);
      if (r == 0) return 0;
      if (NB == 8) return (r == 1) ? 1 : ((r == 2) ? 3 : 4);
      return r;
   endfunction

   function automatic int byte_hi(input int r, input int c);
      return W - 1 - 8 * (4 * c + r);
   endfunction

   logic [W-1:0] enc_data;
   logic [W-1:0] dec_data;
   logic [W-1:0] shifted;

   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < NB; c++) begin : g_col
         localparam int SH  = row_off(r);
         localparam int ENC = (c + SH) % NB;
         localparam int DEC = (c + NB - SH) % NB;
         assign enc_data[byte_hi(r, c) -: 8] = i_Data[byte_hi(r, ENC) -: 8];
         assign dec_data[byte_hi(r, c) -: 8] = i_Data[byte_hi(r, DEC) -: 8];
      end
   end

   assign shifted = i_fDec ? dec_data : enc_data;

   logic             m_valid;
   logic [W-1:0]     m_data;
   logic             m_fdec;
   logic             s_valid;
   logic [W-1:0]     s_data;
   logic             s_fdec;
   logic [CNT_W-1:0] cnt;
   logic             acc;
   logic             pop;

   // Handshake: a beat moves on a side only in a cycle where that side's valid and
   // ready are both high; the producer holds data/fDec stable while valid && !ready.
   assign acc = i_Valid && o_Ready;
   assign pop = m_valid && i_Ready;

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_fdec  <= 1'b0;
         s_valid <= 1'b0;
         s_data  <= '0;
         s_fdec  <= 1'b0;
         cnt     <= '0;
      end else if (i_Clr) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         cnt     <= '0;
      end else begin
         if (pop) cnt <= cnt + CNT_W'(1);
         if (!m_valid || pop) begin
            if (s_valid) begin
               m_data  <= s_data;
               m_fdec  <= s_fdec;
               m_valid <= 1'b1;
               s_valid <= 1'b0;
            end else if (acc) begin
               m_data  <= shifted;
               m_fdec  <= i_fDec;
               m_valid <= 1'b1;
            end else begin
               m_valid <= 1'b0;
            end
         end else if (acc) begin
            // Main is stalled: park the beat in the skid entry, which drops o_Ready.
            s_data  <= shifted;
            s_fdec  <= i_fDec;
            s_valid <= 1'b1;
         end
      end
   end

   assign o_Valid = m_valid;
   assign o_Ready = !s_valid;
   assign o_Data  = m_data;
   assign o_fDec  = m_fdec;
   assign o_Cnt   = cnt;

endmodule

// File: tb/tb_shift_rows_stream.sv
// Bench for shift_rows_stream: an NB=4 instance for streaming/handshake checks
// and an NB=8, CNT_W=2 instance for wide-block routing and counter wrap.
module tb_shift_rows_stream;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         a_clr = 0, a_valid = 0, a_ready, a_fdec = 0, a_ovalid, a_iready = 0, a_ofdec;
   logic [127:0] a_data = '0, a_odata;
   logic [15:0]  a_cnt;
   logic         b_clr = 0, b_valid = 0, b_ready, b_fdec = 0, b_ovalid, b_iready = 0, b_ofdec;
   logic [255:0] b_data = '0, b_odata;
   logic [1:0]   b_cnt;

   shift_rows_stream #(.NB(4), .CNT_W(16)) dut4 (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Clr(a_clr), .i_Valid(a_valid), .o_Ready(a_ready),
      .i_Data(a_data), .i_fDec(a_fdec), .o_Valid(a_ovalid), .i_Ready(a_iready),
      .o_Data(a_odata), .o_fDec(a_ofdec), .o_Cnt(a_cnt));

   shift_rows_stream #(.NB(8), .CNT_W(2)) dut8 (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Clr(b_clr), .i_Valid(b_valid), .o_Ready(b_ready),
      .i_Data(b_data), .i_fDec(b_fdec), .o_Valid(b_ovalid), .i_Ready(b_iready),
      .o_Data(b_odata), .o_fDec(b_ofdec), .o_Cnt(b_cnt));

   int n_vec = 0;
   int n_err = 0;
   int a_acc = 0;
   int a_cnt_exp = 0;
   int b_cnt_exp = 0;
   logic [128:0] exp_q[$];

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: unpack into a row/column byte matrix and rotate each row.
   function automatic logic [255:0] ref_shift(input int nb, input logic [255:0] d, input bit dec);
      logic [7:0] s[4][8];
      logic [255:0] o;
      int sh, src;
      o = '0;
      for (int c = 0; c < nb; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = d[32*nb-1-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++) begin
         if (r == 0) sh = 0;
         else if (nb == 8) sh = (r == 1) ? 1 : ((r == 2) ? 3 : 4);
         else sh = r;
         for (int c = 0; c < nb; c++) begin
            src = dec ? (c - sh + nb) % nb : (c + sh) % nb;
            o[32*nb-1-8*(4*c+r) -: 8] = s[r][src];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // One cycle on the NB=4 instance: drive at negedge, score the handshake, release after posedge.
   task automatic a_step(input bit v, input logic [127:0] d, input bit dec, input bit rdy,
                         input bit no_bubble);
      logic [255:0] t;
      logic [128:0] e;
      @(negedge clk);
      a_valid = v; a_data = d; a_fdec = dec; a_iready = rdy;
      #1;
      if (no_bubble) chk("no_bubble", a_ovalid, 1);
      if (a_ovalid && rdy) begin
         if (exp_q.size() == 0) chk("q_underflow", exp_q.size(), 1);
         else begin
            e = exp_q.pop_front();
            chk("a_beat", {a_ofdec, a_odata}, e);
            a_cnt_exp++;
         end
      end
      if (v && a_ready) begin
         t = ref_shift(4, {128'b0, d}, dec);
         exp_q.push_back({dec, t[127:0]});
         a_acc++;
      end
      @(posedge clk);
      #1 a_valid = 0; a_iready = 0;
   endtask

   task automatic a_clear();
      @(negedge clk);
      a_clr = 1;
      @(posedge clk);
      #1 a_clr = 0;
      exp_q.delete();
      a_cnt_exp = 0;
   endtask

   task automatic b_send(input logic [255:0] d, input bit dec, output logic [255:0] res);
      @(negedge clk);
      b_valid = 1; b_data = d; b_fdec = dec; b_iready = 0;
      chk("b_ready", b_ready, 1);
      @(posedge clk);
      #1 b_valid = 0;
      @(negedge clk);
      #1;
      chk("b_valid", b_ovalid, 1);
      chk("b_data", b_odata, ref_shift(8, d, dec));
      chk("b_fdec", b_ofdec, dec);
      res = b_odata;
      b_iready = 1;
      @(posedge clk);
      #1 b_iready = 0;
      b_cnt_exp++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [127:0] beats[5];
      logic [255:0] in8, r1, r2;
      logic [255:0] t;
      int guard;

      #3;
      chk("rst_a_valid", a_ovalid, 0);
      chk("rst_a_ready", a_ready, 1);
      chk("rst_a_data", a_odata, 0);
      chk("rst_a_fdec", a_ofdec, 0);
      chk("rst_a_cnt", a_cnt, 0);
      chk("rst_b_valid", b_ovalid, 0);
      chk("rst_b_cnt", b_cnt, 0);
      @(negedge clk);
      rst_n = 1;

      // FIPS-197 vectors, encrypt then decrypt
      a_step(1, 128'hd42711aee0bf98f1b8b45de51e415230, 0, 0, 0);
      @(negedge clk); #1;
      chk("enc_latency", a_ovalid, 1);
      chk("enc_vec", a_odata, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
      a_step(0, '0, 0, 1, 0);
      @(negedge clk); #1;
      chk("enc_cnt", a_cnt, a_cnt_exp);
      a_step(1, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1, 0, 0);
      @(negedge clk); #1;
      chk("dec_vec", a_odata, 128'hd42711aee0bf98f1b8b45de51e415230);
      chk("dec_fdec", a_ofdec, 1);
      a_step(0, '0, 0, 1, 0);

      // Backpressure: only main + skid fill, then a gap-free drain
      a_clear();
      a_acc = 0;
      for (int i = 0; i < 5; i++) beats[i] = rnd128();
      for (int i = 0; i < 4; i++) a_step(1, beats[a_acc], 0, 0, 0);
      @(negedge clk); #1;
      chk("bp_accepted", a_acc, 2);
      chk("bp_ready", a_ready, 0);
      guard = 0;
      while (a_cnt_exp < 5 && guard < 20) begin
         a_step(a_acc < 5, beats[a_acc < 5 ? a_acc : 0], 0, 1, 1);
         guard++;
      end
      chk("bp_delivered", a_cnt_exp, 5);
      @(negedge clk); #1;
      chk("bp_cnt", a_cnt, 5);

      // Random handshakes, mode alternating per accepted beat
      a_clear();
      a_acc = 0;
      for (int i = 0; i < 300; i++)
         a_step($urandom_range(0, 1), rnd128(), a_acc[0], $urandom_range(0, 1), 0);
      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
         a_step(0, '0, 0, 1, 0);
         guard++;
      end
      chk("rand_drain", exp_q.size(), 0);
      @(negedge clk); #1;
      chk("rand_cnt", a_cnt, a_cnt_exp[15:0]);

      // Flush with both entries full, an input offered and a pop in the same cycle
      a_step(1, rnd128(), 0, 0, 0);
      a_step(1, rnd128(), 1, 0, 0);
      @(negedge clk);
      a_clr = 1; a_valid = 1; a_data = rnd128(); a_iready = 1;
      @(posedge clk);
      #1 a_clr = 0; a_valid = 0; a_iready = 0;
      exp_q.delete();
      a_cnt_exp = 0;
      @(negedge clk); #1;
      chk("clr_valid", a_ovalid, 0);
      chk("clr_ready", a_ready, 1);
      chk("clr_cnt", a_cnt, 0);
      for (int i = 0; i < 3; i++) begin
         a_step(0, '0, 0, 1, 0);
         chk("clr_no_beat", a_ovalid, 0);
      end

      // Asynchronous reset between clock edges
      a_step(1, rnd128(), 0, 1, 0);
      a_step(1, rnd128(), 1, 1, 0);
      a_step(1, rnd128(), 0, 0, 0);
      a_step(1, rnd128(), 0, 0, 0);
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("arst_valid", a_ovalid, 0);
      chk("arst_ready", a_ready, 1);
      chk("arst_data", a_odata, 0);
      chk("arst_fdec", a_ofdec, 0);
      chk("arst_cnt", a_cnt, 0);
      exp_q.delete();
      a_cnt_exp = 0;
      @(negedge clk);
      rst_n = 1;
      a_valid = 1; a_data = rnd128(); a_fdec = 1;
      #1 chk("arst_first_ready", a_ready, 1);
      t = ref_shift(4, {128'b0, a_data}, 1);
      exp_q.push_back({1'b1, t[127:0]});
      @(posedge clk);
      #1 a_valid = 0;
      @(negedge clk); #1;
      chk("arst_first_valid", a_ovalid, 1);
      a_step(0, '0, 0, 1, 0);

      // NB=8: incrementing bytes, round trip, then counter wrap at CNT_W=2
      for (int k = 0; k < 32; k++) in8[255-8*k -: 8] = k[7:0];
      b_send(in8, 0, r1);
      chk("b8_head", r1[255:224], 32'h00050E13);
      chk("b8_tail", r1[31:0], 32'h1C010A0F);
      b_send(r1, 1, r2);
      chk("b8_restore", r2, in8);
      chk("b8_cnt", b_cnt, b_cnt_exp);
      @(negedge clk);
      b_clr = 1;
      @(posedge clk);
      #1 b_clr = 0;
      for (int i = 0; i < 5; i++) b_send({rnd128(), rnd128()}, $urandom_range(0, 1), r1);
      @(negedge clk); #1;
      chk("b_wrap", b_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/shift_rows_stream.md
Name: shift_rows_stream

Overview:
- Parametrised, pipelined ShiftRows/InvShiftRows stage for the Rijndael datapath.
- Supports block widths of Nb = 4, 6 or 8 columns, with the direction selected per beat.
- Sits between SubBytes and MixColumns in the round pipeline, using valid/ready handshakes on both sides.
- Has a 2-entry elastic buffer (main + skid), so upstream ready is registered and full throughput holds under downstream backpressure.

Parameters:
- NB, 4, state columns; legal values 4, 6, 8. Any other value is an elaboration error.
- CNT_W, 16, width of the delivered-beat counter.

Ports:
- i_Clk  in  1  clock, rising edge.
- i_Rst_n  in  1  reset, asynchronous, active-low.
- i_Clr  in  1  synchronous flush; drops buffered beats and clears the counter.
- i_Valid  in  1  input beat valid.
- o_Ready  out  1  stage can accept an input beat.
- i_Data  in  32*NB  input state, column-major, byte k counted from the MSB = row (k mod 4), column (k div 4).
- i_fDec  in  1  0 = ShiftRows, 1 = InvShiftRows; sampled with the beat.
- o_Valid  out  1  output beat valid.
- i_Ready  in  1  downstream accepts the output beat.
- o_Data  out  32*NB  transformed state, same byte layout as i_Data.
- o_fDec  out  1  i_fDec of the beat on o_Data.
- o_Cnt  out  CNT_W  count of delivered beats, modulo 2^CNT_W.

Behaviour:
- Row offsets C1,C2,C3 are 1,2,3 for NB=4 and NB=6, and 1,3,4 for NB=8. Row 0 is never shifted.
- Encrypt: s'[r][c] = s[r][(c+Cr) mod NB].
- Decrypt: s'[r][c] = s[r][(c-Cr) mod NB].
- The transform is pure byte routing with no arithmetic. It is applied combinationally on the input side before capture.
- Handshake:
  - Input transfer occurs when i_Valid && o_Ready.
  - Output transfer occurs when o_Valid && i_Ready.
  - i_Data and i_fDec only need to be valid during the transfer cycle.
  - o_Data and o_fDec are held stable while o_Valid && !i_Ready.
- Storage: main register M drives the outputs; skid register S holds one extra beat. o_Valid = M.valid; o_Ready = !S.valid (registered).
- Per-cycle update (acc = input transfer, pop = output transfer):
  - M empty or pop, S empty, acc: beat loads M.
  - M empty or pop, S empty, no acc: M.valid <= 0 on pop.
  - pop and S full: S moves to M and S.valid <= 0. No acc is possible, since o_Ready = 0.
  - M full, no pop, acc: beat loads S.
- Beat order is preserved. Latency is 1 cycle from input transfer to o_Valid when M is empty. Sustained throughput is 1 beat/cycle with i_Ready held high.
- o_Cnt increments on every output transfer and wraps from 2^CNT_W-1 to 0.
- i_Clr is evaluated with priority over every other event in that cycle:
  - M.valid and S.valid go to 0, o_Cnt goes to 0, and o_Ready goes to 1 next cycle.
  - An input offered in the same cycle is discarded.
  - An output pop in the same cycle is not counted.
- Reset (i_Rst_n = 0, asynchronous): o_Valid = 0, o_Ready = 1, o_Data = 0, o_fDec = 0, o_Cnt = 0, S cleared.
  - Reset asserted mid-transfer loses the buffered beats without any glitch-dependent behaviour.
  - The first input transfer is accepted on the first rising edge after deassertion.

Test Plan:
- NB=4, fDec=0, input d42711aee0bf98f1b8b45de51e415230 -> o_Data = d4bf5d30e0b452aeb84111f11e2798e5, o_Valid 1 cycle later, o_Cnt = 1.
- NB=4, fDec=1, input d4bf5d30e0b452aeb84111f11e2798e5 -> o_Data = d42711aee0bf98f1b8b45de51e415230, o_fDec = 1.
- NB=8, fDec=0, input bytes 00..1F in MSB-first order -> output begins 00 05 0E 13 and ends 1C 01 0A 0F. Also check that a decrypt pass of the result restores the input.
- Backpressure: stream 5 beats with i_Ready = 0 -> 2 beats accepted, then o_Ready = 0. Raise i_Ready -> all 5 beats delivered in order with no bubbles, and o_Cnt = 5.
- Alternate fDec each beat under random i_Valid/i_Ready -> every beat matches the reference model with its own mode.
- i_Clr with M and S full, plus input offered in the same cycle -> next cycle o_Valid = 0, o_Ready = 1, o_Cnt = 0, and the offered beat never appears.
- Async reset mid-stream -> outputs take their reset values immediately, before the next clock edge.
- o_Cnt wrap at CNT_W = 2: 5 deliveries -> o_Cnt = 1.
